// File: rtl/fetch_queue.sv
// Instruction buffer between variable-length fetch and decode: a small circular
// FIFO of {inst, pc, next_pc, mode} with first-word-fall-through read and flush.
module fetch_queue #(
  parameter int DEPTH = 4,
  parameter int PTR_W = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             f_valid,
  input  logic [47:0]      f_inst,
  input  logic [31:0]      f_pc,
  input  logic [31:0]      f_next_pc,
  input  logic             f_mode,
  output logic             f_ready,
  input  logic             flush,
  output logic             d_valid,
  input  logic             d_ready,
  output logic [47:0]      d_inst,
  output logic [31:0]      d_pc,
  output logic [31:0]      d_next_pc,
  output logic             d_mode,
  output logic [PTR_W:0]   count
);

  typedef struct packed {
    logic [47:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        mode;
  } entry_t;

  localparam logic [PTR_W:0]   FULL_CNT = (PTR_W + 1)'(DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE  = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  entry_t           mem_q [DEPTH];
  logic [PTR_W-1:0] wp_q, wp_d;
  logic [PTR_W-1:0] rp_q, rp_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             push, pop;
  entry_t           head;

  // Handshake flags come from registered occupancy only, so there is no
  // combinational path from f_valid or d_ready to the ready/valid outputs.
  assign f_ready = (cnt_q != FULL_CNT);
  assign d_valid = (cnt_q != '0);
  assign push    = f_valid & f_ready & ~flush;
  assign pop     = d_valid & d_ready & ~flush;
  assign count   = cnt_q;

  assign head      = mem_q[rp_q];
  assign d_inst    = d_valid ? head.inst    : '0;
  assign d_pc      = d_valid ? head.pc      : '0;
  assign d_next_pc = d_valid ? head.next_pc : '0;
  assign d_mode    = d_valid ? head.mode    : 1'b0;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path leaves
    // a variable unassigned and no latch can be inferred.
    wp_d  = wp_q;
    rp_d  = rp_q;
    cnt_d = cnt_q;
    if (flush) begin
      wp_d  = '0;
      rp_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wp_d = wp_q + PTR_ONE;
      if (pop)  rp_d = rp_q + PTR_ONE;
      if (push && !pop)      cnt_d = cnt_q + CNT_ONE;
      else if (pop && !push) cnt_d = cnt_q - CNT_ONE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      wp_q  <= '0;
      rp_q  <= '0;
      cnt_q <= '0;
    end else begin
      wp_q  <= wp_d;
      rp_q  <= rp_d;
      cnt_q <= cnt_d;
    end
  end

  // NOTE: storage is deliberately not reset; it is only observable through
  // d_*, which are forced to zero whenever the queue is empty.
  always_ff @(posedge clk) begin
    if (!reset && push) begin
      mem_q[wp_q] <= '{inst: f_inst, pc: f_pc, next_pc: f_next_pc, mode: f_mode};
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue: a queue scoreboard mirrors the FIFO contents
// and every cycle's outputs are compared against it with immediate assertions.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int PTR_W = 2;

  typedef struct {
    logic [47:0] inst;
    logic [31:0] pc;
    logic [31:0] next_pc;
    logic        mode;
  } exp_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             f_valid;
  logic [47:0]      f_inst;
  logic [31:0]      f_pc;
  logic [31:0]      f_next_pc;
  logic             f_mode;
  logic             f_ready;
  logic             flush;
  logic             d_valid;
  logic             d_ready;
  logic [47:0]      d_inst;
  logic [31:0]      d_pc;
  logic [31:0]      d_next_pc;
  logic             d_mode;
  logic [PTR_W:0]   count;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
    .clk(clk), .reset(reset),
    .f_valid(f_valid), .f_inst(f_inst), .f_pc(f_pc), .f_next_pc(f_next_pc),
    .f_mode(f_mode), .f_ready(f_ready), .flush(flush),
    .d_valid(d_valid), .d_ready(d_ready), .d_inst(d_inst), .d_pc(d_pc),
    .d_next_pc(d_next_pc), .d_mode(d_mode), .count(count)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic fv, input logic [31:0] pc, input logic [31:0] npc,
                       input logic mode, input logic dr, input logic fl, input logic rst);
    f_valid   = fv;
    f_pc      = pc;
    f_next_pc = npc;
    f_mode    = mode;
    f_inst    = {pc[15:0], pc ^ 32'hA5A5_0000};
    d_ready   = dr;
    flush     = fl;
    reset     = rst;
  endtask

  // Compare outputs against the scoreboard before the edge, clock once, then
  // update the scoreboard from the stimulus that was applied.
  task automatic step();
    int          n;
    logic        do_push, do_pop;
    logic [PTR_W-1:0] gap;
    exp_t        e;
    n = sb.size();
    check("d_valid", 64'(d_valid), 64'(n != 0));
    check("f_ready", 64'(f_ready), 64'(n != DEPTH));
    check("count",   64'(count),   64'(n));
    if (n != 0) begin
      check("d_inst",    64'(d_inst),    64'(sb[0].inst));
      check("d_pc",      64'(d_pc),      64'(sb[0].pc));
      check("d_next_pc", 64'(d_next_pc), 64'(sb[0].next_pc));
      check("d_mode",    64'(d_mode),    64'(sb[0].mode));
    end else begin
      check("d_inst_zero", 64'(d_inst), 64'(0));
      check("d_pc_zero",   64'(d_pc),   64'(0));
    end
    check("cnt_range", 64'(dut.cnt_q <= (PTR_W + 1)'(DEPTH)), 64'(1));
    gap = dut.wp_q - dut.rp_q;
    check("ptr_gap", 64'(gap), 64'(dut.cnt_q[PTR_W-1:0]));
    do_push = f_valid && (n < DEPTH) && !flush;
    do_pop  = d_ready && (n > 0) && !flush;
    e = '{inst: f_inst, pc: f_pc, next_pc: f_next_pc, mode: f_mode};
    @(posedge clk);
    #1;
    if (reset || flush) begin
      sb.delete();
    end else begin
      if (do_pop)  void'(sb.pop_front());
      if (do_push) sb.push_back(e);
    end
  endtask

  initial begin
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();  // reset then idle

    // Single pass-through with the exact instruction word
    drive(1'b1, 32'h100, 32'h104, 1'b0, 1'b1, 1'b0, 1'b0);
    f_inst = 48'h0000_1234_5678;
    step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("pass_pc", 64'(d_pc), 64'h100);
    check("pass_inst", 64'(d_inst), 64'h1234_5678);
    step();
    step();

    // Fill to full, attempt a fifth push, then drain in order
    drive(1'b1, 32'h10, 32'h11, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h11, 32'h13, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h13, 32'h15, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h15, 32'h16, 1'b1, 1'b0, 1'b0, 1'b0); step();
    check("full_count", 64'(count), 64'(4));
    drive(1'b1, 32'h16, 32'h18, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("drain0_pc", 64'(d_pc), 64'h10);
    repeat (4) step();
    step();

    // Prime two entries, then push and pop together for 10 cycles
    drive(1'b1, 32'h1000, 32'h1004, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h1004, 32'h1008, 1'b0, 1'b0, 1'b0, 1'b0); step();
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 32'h1008 + 32'(4 * i), 32'h100C + 32'(4 * i), 1'b0, 1'b1, 1'b0, 1'b0);
      step();
    end
    check("steady_count", 64'(count), 64'(2));

    // Reach three entries, flush alongside a push, then restart at 0x200
    drive(1'b1, 32'h3000, 32'h3004, 1'b0, 1'b0, 1'b0, 1'b0); step();
    check("pre_flush_count", 64'(count), 64'(3));
    drive(1'b1, 32'h3004, 32'h3008, 1'b0, 1'b1, 1'b1, 1'b0); step();
    drive(1'b1, 32'h200, 32'h204, 1'b0, 1'b0, 1'b0, 1'b0); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("redirect_pc", 64'(d_pc), 64'h200);
    step();

    // Grow to three entries, then reset mid-operation with push and pop active
    drive(1'b1, 32'h400, 32'h406, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h406, 32'h407, 1'b1, 1'b0, 1'b0, 1'b0); step();
    drive(1'b1, 32'h500, 32'h504, 1'b0, 1'b1, 1'b0, 1'b1); step();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0);
    check("post_reset_count", 64'(count), 64'(0));
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
